// File: rtl/z_digit_subtractor.sv
// Digit-serial subtractor: diff = a - b - b_in, DIGIT bits per RUN cycle.
// Borrow generate/propagate chain per digit, borrow registered between digits.
module z_digit_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
    logic             bor_q, done_q, b_out_q, ovf_q;
    logic [KW-1:0]    k_q;

    logic [DIGIT:0]   bor_d;
    logic [DIGIT-1:0] dig_d;
    logic [WIDTH-1:0] res_d;
    logic             last_d;

    // Operands shift right each RUN cycle, so the active digit is always the low DIGIT bits.
    always_comb begin
        bor_d    = '0;
        dig_d    = '0;
        bor_d[0] = bor_q;
        for (int i = 0; i < DIGIT; i++) begin
            dig_d[i]   = a_q[i] ^ b_q[i] ^ bor_d[i];
            bor_d[i+1] = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bor_d[i]);
        end
        res_d = res_q >> DIGIT;
        res_d[WIDTH-1 -: DIGIT] = dig_d;
        last_d = (k_q == KW'(NDIG - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bor_q   <= 1'b0;
            done_q  <= 1'b0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        bor_q   <= b_in;
                        res_q   <= '0;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    bor_q <= bor_d[DIGIT];
                    res_q <= res_d;
                    k_q   <= k_q + KW'(1);
                    // Results are published only here, so diff never shows a partial value.
                    if (last_d) begin
                        state_q <= IDLE;
                        diff_q  <= res_d;
                        b_out_q <= bor_d[DIGIT];
                        ovf_q   <= bor_d[DIGIT-1] ^ bor_d[DIGIT];
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_z_digit_subtractor.sv
// Bench for z_digit_subtractor: arithmetic/timing model checked every cycle,
// plus directed vectors with literal expected results.
module tb_z_digit_subtractor;
    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, b_in = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, b_out, ovf;
    logic [15:0] diff;

    logic        start2 = 1'b0, b_in2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic        busy2, done2, b_out2, ovf2;
    logic [15:0] diff2;

    int n_vec = 0, n_err = 0;

    z_digit_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
        .busy(busy), .done(done), .diff(diff), .b_out(b_out), .ovf(ovf));

    z_digit_subtractor #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .b_in(b_in2),
        .busy(busy2), .done(done2), .diff(diff2), .b_out(b_out2), .ovf(ovf2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a latched op completes NDIG edges after acceptance; result from plain arithmetic.
    int          m_cnt = 0;
    logic        m_done = 0, m_bout = 0, m_ovf = 0, p_bout = 0, p_ovf = 0;
    logic [15:0] m_diff = '0, p_diff = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_done = 0; m_diff = '0; m_bout = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1; m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
                end
            end else if (start) begin
                logic [16:0] full;
                int sr;
                full = {1'b0, a} - {1'b0, b} - {16'd0, b_in};
                sr = int'($signed(a)) - int'($signed(b)) - int'(b_in);
                p_diff = full[15:0];
                p_bout = full[16];
                p_ovf  = (sr < -32768) || (sr > 32767);
                m_cnt  = NDIG;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            chk("busy", busy, m_cnt > 0);
            chk("done", done, m_done);
            chk("diff", diff, m_diff);
            chk("b_out", b_out, m_bout);
            chk("ovf", ovf, m_ovf);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb, input logic eo);
        int n;
        @(negedge clk);
        a = va; b = vb; b_in = vbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb;
        wait_done(n);
        chk("latency", n, NDIG);
        chk("lit_diff", diff, ed);
        chk("lit_bout", b_out, eb);
        chk("lit_ovf", ovf, eo);
    endtask

    initial begin
        int n, cnt;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // start pulsed while busy must be ignored
        @(negedge clk);
        a = 16'h5555; b = 16'h1111; b_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 16'h0001; b = 16'h0002; b_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(n);
        chk("busy_ign_diff", diff, 16'h4444);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("busy_ign_no_2nd_done", cnt, 0);

        // start held high: back-to-back ops, next op accepted in the done cycle
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; b_in = 1'b0; start = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (!done && n < 20);
        chk("b2b_int1", n, NDIG + 1);
        chk("b2b_diff1", diff, 16'h000F);
        a = 16'h0100; b = 16'h0200; b_in = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (!done && n < 20);
        chk("b2b_int2", n, NDIG + 1);
        chk("b2b_diff2", diff, 16'hFEFF);
        chk("b2b_bout2", b_out, 1);
        a = 16'hABCD; b = 16'h1234; b_in = 1'b0;
        n = 0; do begin @(negedge clk); n++; end while (!done && n < 20);
        start = 1'b0;
        chk("b2b_int3", n, NDIG + 1);
        chk("b2b_diff3", diff, 16'h9999);
        chk("b2b_ovf3", ovf, 0);

        // reset mid-run aborts with no done pulse
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_op(16'h0300, 16'h0100, 1'b0, 16'h0200, 1'b0, 1'b0);

        // single-digit configuration
        @(negedge clk);
        a2 = 16'h0005; b2 = 16'h0007; b_in2 = 1'b0; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk("d16_busy", busy2, 1);
        chk("d16_done_early", done2, 0);
        @(negedge clk);
        chk("d16_done", done2, 1);
        chk("d16_busy_fall", busy2, 0);
        chk("d16_diff", diff2, 16'hFFFE);
        chk("d16_bout", b_out2, 1);
        chk("d16_ovf", ovf2, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
